// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_transmitter between NUM_REQ byte producers.
// Tracks the transmitter's busy output through each frame and returns a done pulse to the requester it served.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 3,
  parameter int START_TIMEOUT = 16,
  parameter int ID_W          = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   done,
  output logic [7:0]           tx_data,
  output logic                 tx_send,
  input  logic                 tx_busy,
  output logic                 active,
  output logic [ID_W-1:0]      active_id,
  output logic                 err,
  output logic [ID_W-1:0]      err_id,
  output logic [2:0]           dbg_state
);

  // Handshake: req[i] is a level held with stable data until done[i] pulses for one cycle;
  // tx_send is a one-cycle pulse and tx_busy high means the transmitter owns the line.

  localparam int CNT_W = $clog2(START_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_RELEASE   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_send_q, tx_send_d;
  logic               active_q, active_d;
  logic [ID_W-1:0]    active_id_q, active_id_d;
  logic               err_q, err_d;
  logic [ID_W-1:0]    err_id_q, err_id_d;
  logic [ID_W-1:0]    rr_q, rr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               grant_found;
  logic [ID_W-1:0]    grant_idx;
  logic [7:0]         grant_byte;
  logic               go_release;

  // Two passes give the wrap-around search: first at or above the pointer, then from 0.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_byte  = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && req[i] && (ID_W'(i) >= rr_q)) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(i);
        grant_byte  = req_data[8*i +: 8];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && req[i]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(i);
        grant_byte  = req_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    done_d      = '0;
    tx_data_d   = tx_data_q;
    tx_send_d   = 1'b0;
    active_d    = active_q;
    active_id_d = active_id_q;
    err_d       = err_q;
    err_id_d    = err_id_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    go_release  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!tx_busy && grant_found) begin
          active_id_d = grant_idx;
          tx_data_d   = grant_byte;
          active_d    = 1'b1;
          tx_send_d   = 1'b1;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
            err_d      = 1'b1;
            err_id_d   = active_id_q;
            go_release = 1'b1;
          end
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) go_release = 1'b1;
      end
      S_RELEASE: begin
        rr_d    = (active_id_q == ID_W'(NUM_REQ - 1)) ? '0 : active_id_q + ID_W'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // done and active are registered, so they change together on entry to RELEASE.
    if (go_release) begin
      state_d  = S_RELEASE;
      active_d = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) done_d[i] = (active_id_q == ID_W'(i));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      done_q      <= '0;
      tx_data_q   <= 8'h00;
      tx_send_q   <= 1'b0;
      active_q    <= 1'b0;
      active_id_q <= '0;
      err_q       <= 1'b0;
      err_id_q    <= '0;
      rr_q        <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      tx_data_q   <= tx_data_d;
      tx_send_q   <= tx_send_d;
      active_q    <= active_d;
      active_id_q <= active_id_d;
      err_q       <= err_d;
      err_id_q    <= err_id_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign done      = done_q;
  assign tx_data   = tx_data_q;
  assign tx_send   = tx_send_q;
  assign active    = active_q;
  assign active_id = active_id_q;
  assign err       = err_q;
  assign err_id    = err_id_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a busy model stands in for the transmitter, and a scoreboard
// holds the expected byte and done-index order.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 3;
  localparam int ID_W    = 2;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_ISSUE = 3'd1, ST_WAIT_DONE = 3'd3;

  logic                 clk;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   done;
  logic [7:0]           tx_data;
  logic                 tx_send;
  logic                 active;
  logic [ID_W-1:0]      active_id;
  logic                 err;
  logic [ID_W-1:0]      err_id;
  logic [2:0]           dbg_state;

  logic model_busy, force_busy, model_en;
  int   busy_delay, busy_len;
  wire  tx_busy_w = model_busy | force_busy;

  logic [7:0]      exp_q[$];
  logic [ID_W-1:0] exp_done_q[$];

  int checks, errors;
  int cyc, send_cnt, send_cyc, done_cyc, fall_cyc;
  logic prev_busy;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .START_TIMEOUT(16), .ID_W(ID_W)) dut (
    .clk(clk), .reset(rst_n), .req(req), .req_data(req_data), .done(done),
    .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy_w), .active(active),
    .active_id(active_id), .err(err), .err_id(err_id), .dbg_state(dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Transmitter stand-in: busy rises busy_delay cycles after a send and stays high busy_len cycles.
  initial begin
    model_busy = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (model_en && tx_send === 1'b1) begin
        repeat (busy_delay) @(posedge clk);
        #2 model_busy = 1'b1;
        repeat (busy_len) @(posedge clk);
        #2 model_busy = 1'b0;
      end
    end
  end

  // One cycle of time; every send and done the DUT produces is scored here.
  task tick();
    logic [ID_W-1:0]    e_id;
    logic [7:0]         e_byte;
    logic [NUM_REQ-1:0] e_mask;
    @(negedge clk);
    cyc++;
    if (prev_busy && !tx_busy_w) fall_cyc = cyc;
    prev_busy = tx_busy_w;
    if (tx_send === 1'b1) begin
      send_cnt++;
      send_cyc = cyc;
      checks++;
      if (active !== 1'b1) begin
        errors++;
        $display("FAIL send_active: active=%b required 1", active);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL send_unexpected: tx_data=%h with nothing expected", tx_data);
      end else begin
        e_byte = exp_q.pop_front();
        if (tx_data !== e_byte) begin
          errors++;
          $display("FAIL send_data: tx_data=%h required %h", tx_data, e_byte);
        end
      end
    end
    if (done !== '0) begin
      done_cyc = cyc;
      checks++;
      if (exp_done_q.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: done=%b with nothing expected", done);
      end else begin
        e_id   = exp_done_q.pop_front();
        e_mask = NUM_REQ'(1) << e_id;
        if (done !== e_mask) begin
          errors++;
          $display("FAIL done_mask: done=%b required %b", done, e_mask);
        end
      end
    end
  endtask

  task wait_done(input int budget, output logic [NUM_REQ-1:0] d);
    d = '0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done !== '0) begin
        d = done;
        break;
      end
    end
    checks++;
    if (d === '0) begin
      errors++;
      $display("FAIL wait_done: no done within %0d cycles", budget);
    end
  endtask

  task apply_reset();
    rst_n = 1'b0;
    req   = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({done, tx_data, tx_send, active, active_id, err, err_id} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: done=%b tx_data=%h send=%b active=%b id=%0d err=%b err_id=%0d required all 0",
               done, tx_data, tx_send, active, active_id, err, err_id);
    end
    checks++;
    if (dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state: state=%0d required %0d", dbg_state, ST_IDLE);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task test_single();
    logic [NUM_REQ-1:0] d;
    int sends0;
    apply_reset();
    model_en = 1'b1; busy_delay = 3; busy_len = 10;
    sends0 = send_cnt;
    req_data[15:8] = 8'h8E;
    exp_q.push_back(8'h8E);
    exp_done_q.push_back(1);
    req = 3'b010;
    wait_done(100, d);
    req = 3'b000;
    checks++;
    if (done_cyc != fall_cyc + 1) begin
      errors++;
      $display("FAIL single_done_latency: done at %0d busy fell at %0d, required 1 apart", done_cyc, fall_cyc);
    end
    tick();
    tick();
    checks++;
    if (active !== 1'b0 || send_cnt != sends0 + 1) begin
      errors++;
      $display("FAIL single_after: active=%b sends=%0d required 0 and %0d", active, send_cnt - sends0, 1);
    end
  endtask

  task test_contention();
    logic [NUM_REQ-1:0] d;
    apply_reset();
    model_en = 1'b1; busy_delay = 2; busy_len = 6;
    req_data = {8'h43, 8'h42, 8'h41};
    for (int i = 0; i < NUM_REQ; i++) begin
      exp_q.push_back(req_data[8*i +: 8]);
      exp_done_q.push_back(ID_W'(i));
    end
    req = 3'b111;
    for (int i = 0; i < NUM_REQ; i++) begin
      wait_done(100, d);
      req = req & ~d;
      checks++;
      if (d !== NUM_REQ'(1 << i)) begin
        errors++;
        $display("FAIL contention_order: done=%b required %b", d, NUM_REQ'(1 << i));
      end
    end
  endtask

  task test_rr_wrap();
    logic [NUM_REQ-1:0] d;
    int guard;
    model_en = 1'b1; busy_delay = 2; busy_len = 5;
    req_data[7:0]   = 8'hA0;
    req_data[23:16] = 8'hC2;
    exp_q.push_back(8'hA0); exp_q.push_back(8'hC2); exp_q.push_back(8'hA1);
    exp_done_q.push_back(0); exp_done_q.push_back(2); exp_done_q.push_back(0);
    req = 3'b101;
    guard = 0;
    while (send_cyc != cyc && guard < 50) begin
      tick();
      guard++;
    end
    req_data[7:0] = 8'hA1;
    wait_done(100, d);
    checks++;
    if (d !== 3'b001 || tx_data !== 8'hA0) begin
      errors++;
      $display("FAIL rr_first: done=%b tx_data=%h required 001 and a0", d, tx_data);
    end
    wait_done(100, d);
    req[2] = 1'b0;
    checks++;
    if (d !== 3'b100) begin
      errors++;
      $display("FAIL rr_wrap: done=%b required 100", d);
    end
    wait_done(100, d);
    req[0] = 1'b0;
  endtask

  task test_timeout();
    logic [NUM_REQ-1:0] d;
    int guard;
    apply_reset();
    model_en = 1'b0;
    req_data[23:16] = 8'h5A;
    exp_q.push_back(8'h5A);
    exp_done_q.push_back(2);
    req = 3'b100;
    guard = 0;
    while (send_cyc != cyc && guard < 50) begin
      tick();
      guard++;
    end
    tick();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early_err: err=%b required 0", err);
    end
    wait_done(100, d);
    req = 3'b000;
    checks++;
    if (done_cyc != send_cyc + 17) begin
      errors++;
      $display("FAIL timeout_latency: done %0d cycles after send, required 17", done_cyc - send_cyc);
    end
    checks++;
    if (err !== 1'b1 || err_id !== 2'd2) begin
      errors++;
      $display("FAIL timeout_err: err=%b err_id=%0d required 1 and 2", err, err_id);
    end
    model_en = 1'b1; busy_delay = 3; busy_len = 5;
    req_data[15:8] = 8'h77;
    exp_q.push_back(8'h77);
    exp_done_q.push_back(1);
    req = 3'b010;
    wait_done(100, d);
    req = 3'b000;
    checks++;
    if (d !== 3'b010 || err !== 1'b1 || err_id !== 2'd2) begin
      errors++;
      $display("FAIL timeout_recover: done=%b err=%b err_id=%0d required 010, 1, 2", d, err, err_id);
    end
  endtask

  task test_async_reset();
    logic [NUM_REQ-1:0] d;
    int guard;
    model_en = 1'b1; busy_delay = 2; busy_len = 20;
    req_data[15:8] = 8'h66;
    exp_q.push_back(8'h66);
    req = 3'b010;
    guard = 0;
    while (dbg_state !== ST_WAIT_DONE && guard < 60) begin
      tick();
      guard++;
    end
    checks++;
    if (dbg_state !== ST_WAIT_DONE) begin
      errors++;
      $display("FAIL areset_reach: state=%0d required %0d", dbg_state, ST_WAIT_DONE);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (tx_send !== 1'b0 || active !== 1'b0 || err !== 1'b0 || done !== '0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL areset_immediate: send=%b active=%b err=%b done=%b state=%0d required 0,0,0,000,0",
               tx_send, active, err, done, dbg_state);
    end
    req = 3'b101;
    req_data[7:0]   = 8'hD0;
    req_data[23:16] = 8'hD2;
    exp_q.push_back(8'hD0); exp_q.push_back(8'hD2);
    exp_done_q.push_back(0); exp_done_q.push_back(2);
    tick();
    tick();
    rst_n = 1'b1;
    wait_done(200, d);
    req = req & ~d;
    checks++;
    if (d !== 3'b001) begin
      errors++;
      $display("FAIL areset_pointer: done=%b required 001", d);
    end
    wait_done(200, d);
    req = req & ~d;
  endtask

  task test_prebusy();
    logic [NUM_REQ-1:0] d;
    int sends0;
    apply_reset();
    model_en = 1'b1; busy_delay = 2; busy_len = 4;
    force_busy = 1'b1;
    sends0 = send_cnt;
    req_data[7:0] = 8'h33;
    exp_q.push_back(8'h33);
    exp_done_q.push_back(0);
    req = 3'b001;
    repeat (10) tick();
    checks++;
    if (send_cnt != sends0 || active !== 1'b0) begin
      errors++;
      $display("FAIL prebusy_hold: sends=%0d active=%b required 0 and 0", send_cnt - sends0, active);
    end
    force_busy = 1'b0;
    tick();
    checks++;
    if (active !== 1'b1 || dbg_state !== ST_ISSUE) begin
      errors++;
      $display("FAIL prebusy_grant: active=%b state=%0d required 1 and %0d", active, dbg_state, ST_ISSUE);
    end
    wait_done(100, d);
    req = 3'b000;
  endtask

  initial begin
    checks = 0; errors = 0;
    cyc = 0; send_cnt = 0; send_cyc = -1; done_cyc = -1; fall_cyc = -1;
    prev_busy = 1'b0;
    req = '0; req_data = '0;
    force_busy = 1'b0; model_en = 1'b0; busy_delay = 3; busy_len = 10;
    test_reset();
    test_single();
    test_contention();
    test_rr_wrap();
    test_timeout();
    test_async_reset();
    test_prebusy();
    repeat (5) tick();
    checks++;
    if (exp_q.size() != 0 || exp_done_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d bytes and %0d dones left, required 0 and 0",
               exp_q.size(), exp_done_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
